lsu_mem_initiator: RTL and testbench

Initiator side of the team's single-word memory request/ready interface. It accepts one byte, halfword or word load/store command at a time from the core and drives `req`/`addr`/`wen`/`wdata`/`be` toward a memory responder. It holds the request stable until the responder asserts `ready`, then returns aligned and extended load data or a store completion. It also flags misaligned accesses and bounds the wait with a timeout. It sits between the core's execute stage and the crossbar/memory port.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_mem_initiator_if.sv | 15 +
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_mem_initiator.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory initiator: access sizes, FSM states,
// the registered command record and the load-extension helper.
package lsu_pkg;

    // Width of the address field carried in the registered command.
    localparam int LsuAddrWidth = 32;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    // Size is kept as raw bits so the illegal encoding 3 can be carried.
    typedef struct packed {
        logic                    we;
        logic [1:0]              size;
        logic                    is_signed;
        logic [LsuAddrWidth-1:0] addr;
        logic [31:0]             wdata;
    } lsu_cmd_t;

    // Extend a byte (low 8 bits of data) or a half (all 16 bits) to 32 bits.
    function automatic logic [31:0] extend_load(input logic [15:0] data,
                                                input logic        is_half,
                                                input logic        is_signed);
        logic [31:0] res;
        if (is_half) begin
            res = {{16{is_signed & data[15]}}, data};
        end else begin
            res = {{24{is_signed & data[7]}}, data[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Single-word memory request/ready bus between the LSU and a responder.
interface lsu_mem_initiator_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-3:0] addr;
    logic                  wen;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic [31:0]           rdata;
    logic                  ready;

    modport master (output req, addr, wen, wdata, be, input rdata, ready);
    modport slave  (input req, addr, wen, wdata, be, output rdata, ready);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detection, store byte enables and
// lane replication, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    assign half_sel_s = offset[1] ? rdata[31:16] : rdata[15:0];

    // Pick the addressed byte lane out of the read word.
    always_comb begin
        byte_sel_s = 8'h00;
        case (offset)
            2'd0:    byte_sel_s = rdata[7:0];
            2'd1:    byte_sel_s = rdata[15:8];
            2'd2:    byte_sel_s = rdata[23:16];
            2'd3:    byte_sel_s = rdata[31:24];
            default: byte_sel_s = 8'h00;
        endcase
    end

    // Per-size encoding; size 3 is reported as misaligned with no lanes.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata_rep  = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        case (size)
            SizeByte: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = extend_load({8'h00, byte_sel_s}, 1'b0, is_signed);
            end
            SizeHalf: begin
                misaligned = offset[0];
                be         = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = extend_load(half_sel_s, 1'b1, is_signed);
            end
            SizeWord: begin
                misaligned = (offset != 2'd0);
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU memory initiator: accepts one load/store at a time, drives a held
// request until ready (or timeout), then pulses a completion with extended
// load data. ADDR_WIDTH must not exceed LsuAddrWidth.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = LsuAddrWidth,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  signed_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    lsu_mem_initiator_if.master   mem
);
    state_e      state_r;
    lsu_cmd_t    cmd_r;
    logic [31:0] cnt_r;
    logic        ready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        mem_req_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;

    logic [1:0]  al_size_s;
    logic [1:0]  al_off_s;
    logic        al_signed_s;
    logic [31:0] al_wdata_s;
    logic        al_misaligned_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_rep_s;
    logic [31:0] al_rdata_ext_s;

    // The aligner sees the incoming command while idle (to encode the
    // request) and the registered command afterwards (to extract load data).
    always_comb begin
        al_size_s   = cmd_r.size;
        al_off_s    = cmd_r.addr[1:0];
        al_signed_s = cmd_r.is_signed;
        al_wdata_s  = cmd_r.wdata;
        case (state_r)
            StIdle: begin
                al_size_s   = size_i;
                al_off_s    = addr_i[1:0];
                al_signed_s = signed_i;
                al_wdata_s  = wdata_i;
            end
            default: begin
                al_size_s   = cmd_r.size;
                al_off_s    = cmd_r.addr[1:0];
                al_signed_s = cmd_r.is_signed;
                al_wdata_s  = cmd_r.wdata;
            end
        endcase
    end

    lsu_align u_align (
        .size       (al_size_s),
        .offset     (al_off_s),
        .is_signed  (al_signed_s),
        .wdata      (al_wdata_s),
        .rdata      (mem.rdata),
        .misaligned (al_misaligned_s),
        .be         (al_be_s),
        .wdata_rep  (al_wdata_rep_s),
        .rdata_ext  (al_rdata_ext_s)
    );

    // Command FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= StIdle;
            cmd_r       <= '0;
            cnt_r       <= 32'd0;
            ready_r     <= 1'b1;
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
        end else begin
            rvalid_r <= 1'b0;
            case (state_r)
                StIdle: begin
                    if (valid_i) begin
                        cmd_r   <= '{we: we_i, size: size_i, is_signed: signed_i,
                                     addr: LsuAddrWidth'(addr_i), wdata: wdata_i};
                        ready_r <= 1'b0;
                        if (al_misaligned_s) begin
                            state_r  <= StResp;
                            rvalid_r <= 1'b1;
                            err_r    <= 1'b1;
                            rdata_r  <= 32'h0000_0000;
                        end else begin
                            state_r     <= StReq;
                            mem_req_r   <= 1'b1;
                            mem_wdata_r <= al_wdata_rep_s;
                            mem_be_r    <= we_i ? al_be_s : 4'b0000;
                            cnt_r       <= 32'd0;
                        end
                    end
                end
                StReq: begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (mem.ready) begin
                        state_r   <= StResp;
                        mem_req_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        err_r     <= 1'b0;
                        rdata_r   <= cmd_r.we ? 32'h0000_0000 : al_rdata_ext_s;
                    end else if ((TIMEOUT > 0) && ((cnt_r + 32'd1) == 32'(TIMEOUT))) begin
                        state_r   <= StResp;
                        mem_req_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        err_r     <= 1'b1;
                        rdata_r   <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                StResp: begin
                    state_r <= StIdle;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= StIdle;
                    ready_r   <= 1'b1;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_r;
    assign rvalid_o  = rvalid_r;
    assign rdata_o   = rdata_r;
    assign err_o     = err_r;
    assign mem.req   = mem_req_r;
    assign mem.addr  = cmd_r.addr[ADDR_WIDTH-1:2];
    assign mem.wen   = cmd_r.we;
    assign mem.wdata = mem_wdata_r;
    assign mem.be    = mem_be_r;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed vector table, reset corner cases and
// randomized commands against a byte-level memory reference model.
module tb_lsu_mem_initiator;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic        signed_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    lsu_mem_initiator_if #(.ADDR_WIDTH(32)) mif ();

    lsu_mem_initiator #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .we_i(we_i), .size_i(size_i), .signed_i(signed_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem(mif)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- responder: 16 words, programmable delay ----------------
    logic [31:0] rsp_mem [16];
    logic [31:0] init_w  [16];
    logic [31:0] model_mem [16];
    bit          do_init = 1'b0;
    int          rsp_cnt;
    int          rsp_delay = 0;
    bit          rsp_never = 1'b0;

    assign mif.ready = mif.req && !rsp_never && (rsp_cnt == rsp_delay);
    assign mif.rdata = mif.ready ? rsp_mem[mif.addr[3:0]] : 32'h0BAD_0BAD;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_cnt <= 0;
        else if (mif.req && !mif.ready) rsp_cnt <= rsp_cnt + 1;
        else rsp_cnt <= 0;
    end

    always @(posedge clk_i) begin
        if (do_init) begin
            for (int i = 0; i < 16; i++) rsp_mem[i] <= init_w[i];
        end else if (mif.req && mif.ready && mif.wen) begin
            for (int l = 0; l < 4; l++)
                if (mif.be[l]) rsp_mem[mif.addr[3:0]][8*l +: 8] <= mif.wdata[8*l +: 8];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [31:0] w, input int sz,
                                               input int off, input bit sgn);
        longint unsigned span;
        longint v;
        span = 64'd1 << (8 * (1 << sz));
        v = longint'((longint'(w) >> (8 * off)) % span);
        if (sgn && v >= longint'(span / 2)) v = v - longint'(span);
        return v[31:0];
    endfunction

    task automatic model_store(input int idx, input int sz, input int off, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++)
            model_mem[idx][8*(off+k) +: 8] = wd[8*k +: 8];
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Issue one command and observe it through its completion pulse.
    task automatic run_cmd(input bit we, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input bit nev,
                           output logic [31:0] rd, output bit er, output int lat,
                           output int reqc, output bit stable,
                           output logic [3:0] be0, output logic [31:0] wd0,
                           output logic [29:0] ad0);
        rsp_delay = dly;
        rsp_never = nev;
        check("ready_idle", 64'(ready_o), 64'd1);
        valid_i = 1'b1; we_i = we; size_i = sz; signed_i = sg; addr_i = a; wdata_i = wd;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1; reqc = 0; stable = 1'b1; be0 = 4'h0; wd0 = 32'h0; ad0 = 30'h0;
        while (!rvalid_o && lat < 40) begin
            if (mif.req) begin
                if (reqc == 0) begin
                    be0 = mif.be; wd0 = mif.wdata; ad0 = mif.addr;
                end else if (mif.be !== be0 || mif.wdata !== wd0 || mif.addr !== ad0 ||
                             mif.wen !== we) begin
                    stable = 1'b0;
                end
                reqc++;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        if (!rvalid_o) begin
            errors++; checks++;
            $display("FAIL rvalid_wait actual=none expected=pulse");
        end
        rd = rdata_o;
        er = err_o;
        check("ready_busy", 64'(ready_o), 64'd0);
        @(posedge clk_i); #1;
        check("pulse_width", 64'(rvalid_o), 64'd0);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] a;
        logic [31:0] wd;
        int          dly;
        bit          nev;
        logic [31:0] e_rd;
        bit          e_er;
        int          e_lat;
        int          e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [31:0] rd;
        bit er, stable;
        int lat, reqc;
        logic [3:0] be0;
        logic [31:0] wd0;
        logic [29:0] ad0;

        for (int i = 0; i < 16; i++) init_w[i] = $urandom;
        init_w[0] = 32'hDEADBEEF;
        init_w[1] = 32'hF1BEF1BE;
        init_w[2] = 32'h1234ABCD;
        for (int i = 0; i < 16; i++) model_mem[i] = init_w[i];

        //        we    sz    sg    addr    wdata        dly nev  e_rd          e_er  lat req be       wd
        vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h0,  32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h1,  32'h0,        0, 1'b0, 32'hFFFFFFBE, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[2]  = '{1'b0, 2'd0, 1'b0, 32'h1,  32'h0,        0, 1'b0, 32'h000000BE, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[3]  = '{1'b0, 2'd1, 1'b0, 32'h6,  32'h0,        0, 1'b0, 32'h0000F1BE, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[4]  = '{1'b1, 2'd0, 1'b0, 32'hB,  32'h0000005A, 3, 1'b0, 32'h0,        1'b0, 5, 4, 4'b1000, 32'h5A5A5A5A};
        vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h8,  32'h0,        0, 1'b0, 32'h5A34ABCD, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h2,  32'h0,        0, 1'b0, 32'h0,        1'b1, 1, 0, 4'b0000, 32'h0};
        vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h4,  32'h0,        0, 1'b1, 32'h0,        1'b1, 5, 4, 4'b0000, 32'h0};
        vt[8]  = '{1'b0, 2'd1, 1'b1, 32'h2,  32'h0,        0, 1'b0, 32'hFFFFDEAD, 1'b0, 2, 1, 4'b0000, 32'h0};
        vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h0,  32'h0,        0, 1'b0, 32'h0,        1'b1, 1, 0, 4'b0000, 32'h0};
        vt[10] = '{1'b0, 2'd2, 1'b0, 32'h4,  32'h0,        4, 1'b0, 32'h0,        1'b1, 5, 4, 4'b0000, 32'h0};
        vt[11] = '{1'b1, 2'd1, 1'b0, 32'hE,  32'h00007788, 1, 1'b0, 32'h0,        1'b0, 3, 2, 4'b1100, 32'h77887788};

        // Reset state.
        do_init = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_req", 64'(mif.req), 64'd0);
        check("rst_bus", {mif.addr, mif.be, mif.wen}, 64'd0);
        check("rst_wdata", 64'(mif.wdata), 64'd0);
        do_init = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_cmd(vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, vt[i].dly, vt[i].nev,
                    rd, er, lat, reqc, stable, be0, wd0, ad0);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].e_rd));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].e_er));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].e_lat));
            check($sformatf("vec%0d_req_cycles", i), 64'(reqc), 64'(vt[i].e_req));
            if (reqc > 0) begin
                check($sformatf("vec%0d_stable", i), 64'(stable), 64'd1);
                check($sformatf("vec%0d_be", i), 64'(be0), 64'(vt[i].e_be));
                check($sformatf("vec%0d_addr", i), 64'(ad0), 64'(vt[i].a >> 2));
                if (vt[i].we) check($sformatf("vec%0d_wdata", i), 64'(wd0), 64'(vt[i].e_wd));
            end
            if (vt[i].we && !vt[i].e_er)
                model_store(int'(vt[i].a[5:2]), int'(vt[i].sz), int'(vt[i].a[1:0]), vt[i].wd);
        end

        // Reset asserted while a request is pending.
        rsp_never = 1'b1;
        valid_i = 1'b1; we_i = 1'b0; size_i = 2'd2; signed_i = 1'b0; addr_i = 32'h10;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("req_before_rst", 64'(mif.req), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_req", 64'(mif.req), 64'd0);
        check("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_mid_ready", 64'(ready_o), 64'd1);
        check("rst_mid_bus", {mif.addr, mif.be}, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        begin
            int pulses = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk_i); #1;
                if (rvalid_o || mif.req) pulses++;
            end
            check("rst_no_completion", 64'(pulses), 64'd0);
        end
        rsp_never = 1'b0;

        // Randomized commands against the reference model.
        for (int n = 0; n < 150; n++) begin
            bit          we, sg, mis;
            logic [1:0]  sz;
            logic [31:0] a, wd, e_rd;
            int          dly, nb, idx, off, e_lat;
            bit          e_er;
            we  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 63));
            wd  = $urandom;
            dly = $urandom_range(0, 5);
            idx = int'(a[5:2]);
            off = int'(a[1:0]);
            nb  = 1 << sz;
            mis = (sz == 2'd3) || ((a % nb) != 0);
            e_rd = 32'h0;
            if (mis) begin
                e_er = 1'b1; e_lat = 1;
            end else if (dly >= 4) begin
                e_er = 1'b1; e_lat = 5;
            end else begin
                e_er = 1'b0; e_lat = dly + 2;
                if (we) model_store(idx, int'(sz), off, wd);
                else e_rd = model_load(model_mem[idx], int'(sz), off, sg);
            end
            run_cmd(we, sz, sg, a, wd, dly, 1'b0, rd, er, lat, reqc, stable, be0, wd0, ad0);
            check($sformatf("rnd%0d_rdata", n), 64'(rd), 64'(e_rd));
            check($sformatf("rnd%0d_err", n), 64'(er), 64'(e_er));
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(e_lat));
            if (reqc > 0) check($sformatf("rnd%0d_stable", n), 64'(stable), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
